// File: rtl/immed_builder.sv
// Registered immediate-formation stage: widens an IMM_W-bit immediate to DATA_W
// with sign/zero extension, high-load, or concatenation with a latched prefix.
// A one-entry valid/ready register decouples decode from the operand mux.
module immed_builder #(
  parameter int IMM_W  = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  immed,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_immed,
  output logic              pfx_pending,
  output logic              pfx_err
);

  localparam int PFX_W = DATA_W - IMM_W;

  typedef enum logic [1:0] {
    M_SEXT   = 2'b00,
    M_ZEXT   = 2'b01,
    M_HIGH   = 2'b10,
    M_PREFIX = 2'b11
  } mode_e;

  // Sign-extend the raw immediate to the datapath width.
  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    logic signed [IMM_W-1:0] s;
    s = v;
    return DATA_W'(s);
  endfunction

  // Zero-extend the raw immediate to the datapath width.
  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] v);
    return DATA_W'(v);
  endfunction

  // Place the immediate in the upper bits; low PFX_W bits are zero.
  function automatic logic [DATA_W-1:0] high_imm(input logic [IMM_W-1:0] v);
    return {v, {PFX_W{1'b0}}};
  endfunction

  // Join a latched prefix with the immediate that completes it.
  function automatic logic [DATA_W-1:0] cat_imm(input logic [PFX_W-1:0] p,
                                                input logic [IMM_W-1:0] v);
    return {p, v};
  endfunction

  // ---- stage p0: input handshake and result formation ----
  logic              out_vld_p1;
  logic [DATA_W-1:0] ext_immed_p1;
  logic [PFX_W-1:0]  pfx_reg_p1;
  logic              pfx_pend_p1;
  logic              pfx_err_p1;

  mode_e             mode_p0;
  logic              acc_p0;
  logic              is_pfx_p0;
  logic [DATA_W-1:0] result_p0;

  assign mode_p0   = mode_e'(mode);
  assign in_ready  = !out_vld_p1 || out_ready;
  assign acc_p0    = in_valid && in_ready;
  assign is_pfx_p0 = (mode_p0 == M_PREFIX);

  // Select the widened value; a pending prefix overrides SEXT/ZEXT.
  always_comb begin
    result_p0 = '0;
    unique case (mode_p0)
      M_SEXT:   result_p0 = pfx_pend_p1 ? cat_imm(pfx_reg_p1, immed) : sext_imm(immed);
      M_ZEXT:   result_p0 = pfx_pend_p1 ? cat_imm(pfx_reg_p1, immed) : zext_imm(immed);
      M_HIGH:   result_p0 = high_imm(immed);
      M_PREFIX: result_p0 = '0;
      default:  result_p0 = '0;
    endcase
  end

  // ---- stage p1: output register and prefix state ----
  // Flush drops the same-edge input and clears pending state without an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_p1   <= 1'b0;
      ext_immed_p1 <= '0;
      pfx_reg_p1   <= '0;
      pfx_pend_p1  <= 1'b0;
      pfx_err_p1   <= 1'b0;
    end else begin
      pfx_err_p1 <= 1'b0;
      if (flush) begin
        out_vld_p1  <= 1'b0;
        pfx_pend_p1 <= 1'b0;
      end else begin
        if (acc_p0 && !is_pfx_p0) begin
          out_vld_p1   <= 1'b1;
          ext_immed_p1 <= result_p0;
        end else if (out_ready) begin
          out_vld_p1 <= 1'b0;
        end
        if (acc_p0) begin
          if (is_pfx_p0) begin
            pfx_reg_p1  <= immed[PFX_W-1:0];
            pfx_pend_p1 <= 1'b1;
            pfx_err_p1  <= pfx_pend_p1;
          end else if (pfx_pend_p1) begin
            pfx_pend_p1 <= 1'b0;
            pfx_err_p1  <= (mode_p0 == M_HIGH);
          end
        end
      end
    end
  end

  assign out_valid   = out_vld_p1;
  assign ext_immed   = ext_immed_p1;
  assign pfx_pending = pfx_pend_p1;
  assign pfx_err     = pfx_err_p1;

endmodule

// File: tb/tb_immed_builder.sv
// Self-checking bench for immed_builder: directed cases with literal
// expectations plus randomized traffic compared every cycle to an arithmetic model.
module tb_immed_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  immed = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] ext_immed;
  logic        pfx_pending;
  logic        pfx_err;

  int n_checks = 0;
  int n_fail   = 0;

  immed_builder #(.IMM_W(9), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .immed(immed), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .ext_immed(ext_immed), .pfx_pending(pfx_pending), .pfx_err(pfx_err)
  );

  always #5 clk = ~clk;

  // Behavioural model state (plain integers).
  bit m_known = 0;
  int m_vld = 0, m_ext = 0, m_pend = 0, m_pfx = 0, m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    int v, md, err;
    bit acc;
    v  = int'(immed);
    md = int'(mode);
    if (rst) begin
      m_vld = 0; m_ext = 0; m_pend = 0; m_pfx = 0; m_err = 0; m_known = 1;
    end else begin
      acc = in_valid && (m_vld == 0 || out_ready);
      err = 0;
      if (flush) begin
        m_vld = 0; m_pend = 0;
      end else if (acc && md == 3) begin
        if (m_pend != 0) err = 1;
        m_pfx  = v % 128;
        m_pend = 1;
        if (out_ready) m_vld = 0;
      end else if (acc && md == 2) begin
        m_ext = (v * 128) % 65536;
        if (m_pend != 0) err = 1;
        m_pend = 0;
        m_vld  = 1;
      end else if (acc) begin
        if (m_pend != 0)       m_ext = m_pfx * 512 + v;
        else if (md == 0 && v >= 256) m_ext = v + 65536 - 512;
        else                   m_ext = v;
        m_pend = 0;
        m_vld  = 1;
      end else if (out_ready) begin
        m_vld = 0;
      end
      m_err = err;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("mdl_out_valid",   int'(out_valid),   m_vld);
      chk("mdl_ext_immed",   int'(ext_immed),   m_ext);
      chk("mdl_pfx_pending", int'(pfx_pending), m_pend);
      chk("mdl_pfx_err",     int'(pfx_err),     m_err);
      chk("mdl_in_ready",    int'(in_ready),    (m_vld == 0 || out_ready) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input int md, input int imm);
    in_valid = v;
    mode     = 2'(md);
    immed    = 9'(imm);
  endtask

  // Advance one edge and stop at the falling edge for directed checks.
  task automatic cyc();
    step();
    @(negedge clk);
  endtask

  initial begin
    // 1. reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    cyc();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ext_immed", int'(ext_immed), 16'h0000);
    chk("rst_pfx_pending", int'(pfx_pending), 0);
    chk("rst_pfx_err", int'(pfx_err), 0);

    // 2. basic widening
    out_ready = 1'b1;
    drv(1, 0, 9'h001); cyc(); chk("sext_001", int'(ext_immed), 16'h0001);
    chk("sext_vld", int'(out_valid), 1);
    drv(1, 0, 9'h100); cyc(); chk("sext_100", int'(ext_immed), 16'hFF00);
    drv(1, 0, 9'h1FF); cyc(); chk("sext_1ff", int'(ext_immed), 16'hFFFF);
    drv(1, 1, 9'h100); cyc(); chk("zext_100", int'(ext_immed), 16'h0100);
    drv(1, 2, 9'h1A5); cyc(); chk("high_1a5", int'(ext_immed), 16'hD280);
    drv(0, 0, 0);      cyc(); chk("drain_vld", int'(out_valid), 0);

    // 3. prefix concatenation
    drv(1, 3, 9'h055); cyc();
    chk("pfx_pend_set", int'(pfx_pending), 1);
    chk("pfx_no_out", int'(out_valid), 0);
    drv(1, 0, 9'h1FF); cyc();
    chk("pfx_pend_clr", int'(pfx_pending), 0);
    chk("pfx_cat", int'(ext_immed), 16'hABFF);
    drv(0, 0, 0); cyc();

    // 4. prefix overwrite and discard
    drv(1, 3, 9'h001); cyc();
    chk("pfx_err_first", int'(pfx_err), 0);
    drv(1, 3, 9'h002); cyc(); chk("pfx_err_ovw", int'(pfx_err), 1);
    drv(0, 0, 0);      cyc(); chk("pfx_err_once", int'(pfx_err), 0);
    drv(1, 1, 9'h000); cyc(); chk("pfx_ovw_cat", int'(ext_immed), 16'h0400);
    drv(1, 3, 9'h07F); cyc();
    drv(1, 2, 9'h001); cyc();
    chk("high_disc_err", int'(pfx_err), 1);
    chk("high_disc_val", int'(ext_immed), 16'h0080);
    chk("high_disc_pend", int'(pfx_pending), 0);
    drv(0, 0, 0); cyc();

    // 5. backpressure
    out_ready = 1'b0;
    drv(1, 0, 9'h005); cyc();
    chk("bp_load", int'(ext_immed), 16'h0005);
    drv(1, 0, 9'h006);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", int'(in_ready), 0);
      cyc();
      chk("bp_stable", int'(ext_immed), 16'h0005);
      chk("bp_vld", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    cyc(); chk("bp_rel_1", int'(ext_immed), 16'h0006);
    drv(1, 0, 9'h007); cyc(); chk("bp_rel_2", int'(ext_immed), 16'h0007);
    drv(0, 0, 0); cyc(); chk("bp_rel_end", int'(out_valid), 0);

    // 6. flush and reset during backpressure
    drv(1, 3, 9'h011); cyc(); chk("fl_pend", int'(pfx_pending), 1);
    flush = 1'b1;
    drv(1, 0, 9'h003); cyc();
    flush = 1'b0;
    chk("fl_vld", int'(out_valid), 0);
    chk("fl_pend_clr", int'(pfx_pending), 0);
    chk("fl_no_err", int'(pfx_err), 0);
    chk("fl_ext_hold", int'(ext_immed), 16'h0007);
    drv(1, 1, 9'h003); cyc(); chk("fl_after", int'(ext_immed), 16'h0003);
    out_ready = 1'b0;
    drv(1, 0, 9'h1F0); cyc(); chk("rbp_vld", int'(out_valid), 1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drv(0, 0, 0);
    out_ready = 1'b1;
    chk("rbp_vld_rst", int'(out_valid), 0);
    chk("rbp_ext_rst", int'(ext_immed), 0);
    chk("rbp_pend_rst", int'(pfx_pending), 0);

    // Randomized traffic, checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      mode      = 2'($urandom_range(0, 3));
      immed     = 9'($urandom_range(0, 511));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) < 1);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
